// File: rtl/comm_master.sv
// Host-side UART command transmitter: sends a 16-bit command as two 8N1 frames, high byte first.
// Optional even parity bit per frame when COMM_PARITY_EN is defined.
module comm_master #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_cmd,
    input  logic [15:0] cmd,
    output logic        TX,
    output logic        cmd_sent
);

`ifdef COMM_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd10;
`else
    localparam logic [3:0] LAST_BIT = 4'd9;
`endif
    localparam logic [15:0] BAUD_MAX = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        send_q, send_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic        tx_q, tx_d;
    logic        sent_q, sent_d;

    // Line level for bit position idx of a frame carrying data.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic [2:0] sel;
        sel = 3'(idx - 4'd1);
        if (idx == 4'd0) begin
            return 1'b0;
        end else if (idx <= 4'd8) begin
            return data[sel];
`ifdef COMM_PARITY_EN
        end else if (idx == 4'd9) begin
            return ^data;
`endif
        end else begin
            return 1'b1;
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        send_d   = send_cmd;
        shadow_d = shadow_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        sent_d   = sent_q;
        tx_d     = 1'b1;

        case (state_q)
            IDLE: begin
                if (send_cmd && !send_q) begin
                    shadow_d = cmd;
                    sent_d   = 1'b0;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = HIGH;
                end
            end
            HIGH, LOW: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = (state_q == HIGH) ? LOW : DONE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DONE: begin
                sent_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // TX follows the next-state position so the start bit appears the clock after the start cycle.
        case (state_d)
            HIGH:    tx_d = frame_bit(shadow_d[15:8], bit_d);
            LOW:     tx_d = frame_bit(shadow_d[7:0], bit_d);
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            send_q   <= 1'b0;
            shadow_q <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            sent_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            send_q   <= send_d;
            shadow_q <= shadow_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            sent_q   <= sent_d;
        end
    end

    assign TX       = tx_q;
    assign cmd_sent = sent_q;

endmodule

// File: tb/tb_comm_master.sv
// Self-checking bench for comm_master: expected line waveform from frame rules plus a mid-bit UART receiver.
module tb_comm_master;

    localparam int B = 16;
`ifdef COMM_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int TOTAL = 2 * FB * B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send_cmd = 1'b0;
    logic [15:0] cmd = '0;
    logic        TX;
    logic        cmd_sent;

    int checks = 0;
    int failures = 0;

    logic wave [0:TOTAL-1];

    typedef struct {
        logic [15:0] c;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    comm_master #(.BAUD_DIV(B)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .send_cmd(send_cmd),
        .cmd(cmd),
        .TX(TX),
        .cmd_sent(cmd_sent)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected line level at clock idx of a command, from frame rules.
    function automatic logic exp_bit(input logic [15:0] c, input int idx);
        int bitpos;
        int frame;
        int pos;
        logic [7:0] byv;
        bitpos = idx / B;
        frame  = bitpos / FB;
        pos    = bitpos % FB;
        byv    = (frame == 0) ? c[15:8] : c[7:0];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return byv[pos-1];
`ifdef COMM_PARITY_EN
        if (pos == 9) return logic'($countones(byv) % 2);
`endif
        return 1'b1;
    endfunction

    // Receiver: find falling edge, sample mid-bit.
    task automatic decode(output logic [7:0] hi, output logic [7:0] lo, output int ok);
        int p;
        logic [7:0] byv;
        p = 0;
        ok = 1;
        hi = '0;
        lo = '0;
        for (int f = 0; f < 2; f++) begin
            while (p < TOTAL && wave[p] !== 1'b0) p++;
            if (p + (FB - 1) * B + B / 2 >= TOTAL) begin
                ok = 0;
                break;
            end
            for (int k = 0; k < 8; k++) byv[k] = wave[p + (k + 1) * B + B / 2];
`ifdef COMM_PARITY_EN
            if (wave[p + 9 * B + B / 2] !== ^byv) ok = 0;
`endif
            if (wave[p + (FB - 1) * B + B / 2] !== 1'b1) ok = 0;
            if (f == 0) hi = byv;
            else lo = byv;
            p = p + (FB - 1) * B + B / 2 + 1;
        end
    endtask

    task automatic run_cmd(input logic [15:0] c, input int hold, input int glitch_at,
                           input int change_at, input bit rel_reset, input string tag,
                           output logic [7:0] hi, output logic [7:0] lo);
        int errs;
        int serr;
        int ok;
        errs = 0;
        serr = 0;
        @(negedge clk);
        cmd = c;
        send_cmd = 1'b1;
        if (rel_reset) rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < TOTAL; i++) begin
            @(negedge clk);
            wave[i] = TX;
            if (TX !== exp_bit(c, i)) errs++;
            if (cmd_sent !== 1'b0) serr++;
            if (i == hold) send_cmd = 1'b0;
            if (i == glitch_at) send_cmd = 1'b1;
            if (glitch_at >= 0 && i == glitch_at + 4) send_cmd = 1'b0;
            if (i == change_at) cmd = 16'h0000;
        end
        check({tag, "_wave_errs"}, errs, 0);
        check({tag, "_sent_busy_errs"}, serr, 0);
        @(negedge clk);
        check({tag, "_tx_done"}, 32'(TX), 1);
        check({tag, "_sent_done_cycle"}, 32'(cmd_sent), 0);
        @(negedge clk);
        check({tag, "_sent_rise"}, 32'(cmd_sent), 1);
        decode(hi, lo, ok);
        check({tag, "_frame_ok"}, ok, 1);
        check({tag, "_decoded"}, {hi, lo}, c);
    endtask

    initial begin
        logic [7:0] h;
        logic [7:0] l;
        int errs;
        logic [15:0] rc;

        tbl[0] = '{c: 16'h1234, hi: 8'h12, lo: 8'h34};
        tbl[1] = '{c: 16'h00FF, hi: 8'h00, lo: 8'hFF};
        tbl[2] = '{c: 16'h8001, hi: 8'h80, lo: 8'h01};
        tbl[3] = '{c: 16'hC33C, hi: 8'hC3, lo: 8'h3C};

        // Reset held with no request
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_sent !== 1'b0) errs++;
        end
        check("reset_idle_errs", errs, 0);

        // Request high on the same clock reset releases
        run_cmd(16'h5555, 5, -1, -1, 1'b1, "rst_edge", h, l);

        // Held request sends exactly once
        run_cmd(16'hFFFF, 100 * B, -1, -1, 1'b0, "held", h, l);
        errs = 0;
        for (int i = 0; i < 100 * B - TOTAL - 2; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_sent !== 1'b1) errs++;
        end
        check("held_no_resend_errs", errs, 0);
        send_cmd = 1'b0;
        @(negedge clk);

        // cmd changed mid high byte
        run_cmd(16'hA503, 5, -1, 3 * B, 1'b0, "cmd_change", h, l);

        // Edge during LOW byte ignored, then a new edge resends
        run_cmd(16'h3C5A, 5, (FB + 3) * B, -1, 1'b0, "busy_edge", h, l);
        errs = 0;
        for (int i = 0; i < 2 * B; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_sent !== 1'b1) errs++;
        end
        check("busy_edge_not_queued_errs", errs, 0);
        run_cmd(16'h9966, 5, -1, -1, 1'b0, "resend", h, l);

        // Table vectors
        for (int v = 0; v < 4; v++) begin
            run_cmd(tbl[v].c, 3, -1, -1, 1'b0, "table", h, l);
            check("table_hi", h, tbl[v].hi);
            check("table_lo", l, tbl[v].lo);
        end

        // Randomized commands with random hold and mid-transfer cmd changes
        for (int r = 0; r < 6; r++) begin
            rc = 16'($urandom);
            run_cmd(rc, $urandom_range(1, TOTAL - 1), -1, $urandom_range(0, TOTAL - 1),
                    1'b0, "random", h, l);
        end

        // Reset in the middle of the high byte (data bit 4 of 0x01 is 0)
        @(negedge clk);
        cmd = 16'h0103;
        send_cmd = 1'b1;
        @(posedge clk);
        repeat (5 * B + B / 2) @(negedge clk);
        send_cmd = 1'b0;
        check("midreset_tx_before", 32'(TX), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_tx_now", 32'(TX), 1);
        check("midreset_sent_now", 32'(cmd_sent), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_sent !== 1'b0) errs++;
        end
        check("midreset_idle_errs", errs, 0);
        run_cmd(16'h0103, 5, -1, -1, 1'b0, "after_reset", h, l);
`ifdef COMM_PARITY_EN
        check("parity_hi", 32'(wave[9 * B + B / 2]), 1);
        check("parity_lo", 32'(wave[FB * B + 9 * B + B / 2]), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
